// File: rtl/id_issue_ctrl_pkg.sv
// Shared codes for the ID/EX issue stage: ALU op/select encodings and latency classes.
package id_issue_ctrl_pkg;

  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned ALU_SEL_W  = 3;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [ALU_OP_W-1:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_LW_OP   = 8'b1110_0011;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOAD  = 3'b111;

  typedef enum logic [1:0] {
    LatAlu  = 2'd0,
    LatLoad = 2'd1,
    LatMul  = 2'd2
  } lat_class_e;

endpackage

// File: rtl/id_issue_ctrl_scoreboard.sv
// Per-register countdown of cycles until a multi-cycle result becomes forwardable.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned LAT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic [LAT_W-1:0]      set_lat,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic                  busy_a,
  output logic                  busy_b
);

  logic [LAT_W-1:0] cnt_q [REG_NUM];
  logic [LAT_W-1:0] cnt_d [REG_NUM];

  always_comb begin
    for (int r = 0; r < int'(REG_NUM); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
    end
    // A new producer overrides this cycle's decrement of its own entry.
    if (set_en) begin
      cnt_d[set_addr] = set_lat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_a = (rd_addr_a != '0) && (cnt_q[rd_addr_a] != '0);
  assign busy_b = (rd_addr_b != '0) && (cnt_q[rd_addr_b] != '0);

endmodule

// File: rtl/id_issue_ctrl.sv
// ID/EX issue stage: operand forwarding, scoreboard hazard stall, flush, registered handoff.
// Optional macro ID_MOVCOND_EN resolves MOVN/MOVZ write enable here instead of in EX.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned LAT_W   = 2,
  parameter int unsigned REG_NUM = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ALU_OP_W-1:0]             in_aluop,
  input  logic [ALU_SEL_W-1:0]            in_alusel,
  input  logic [REG_ADDR_W-1:0]           in_rs,
  input  logic [REG_ADDR_W-1:0]           in_rt,
  input  logic                            in_rs_rd,
  input  logic                            in_rt_rd,
  input  logic [DATA_W-1:0]               in_rs_data,
  input  logic [DATA_W-1:0]               in_rt_data,
  input  logic [DATA_W-1:0]               in_imm,
  input  logic [REG_ADDR_W-1:0]           in_wd,
  input  logic                            in_wreg,
  input  logic [LAT_W-1:0]                in_lat,
  input  logic [NUM_FWD-1:0]              fwd_we,
  input  logic [NUM_FWD*REG_ADDR_W-1:0]   fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0]       fwd_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ALU_OP_W-1:0]             out_aluop,
  output logic [ALU_SEL_W-1:0]            out_alusel,
  output logic [DATA_W-1:0]               out_reg1,
  output logic [DATA_W-1:0]               out_reg2,
  output logic [REG_ADDR_W-1:0]           out_wd,
  output logic                            out_wreg,
  output logic                            stall_o
);

  logic                  busy_a, busy_b;
  logic                  hazard, accept, sb_set;
  logic [DATA_W-1:0]     reg1_res, reg2_res;
  logic                  wreg_res;

  logic                  out_valid_q, out_valid_d;
  logic [ALU_OP_W-1:0]   out_aluop_q, out_aluop_d;
  logic [ALU_SEL_W-1:0]  out_alusel_q, out_alusel_d;
  logic [DATA_W-1:0]     out_reg1_q, out_reg1_d;
  logic [DATA_W-1:0]     out_reg2_q, out_reg2_d;
  logic [REG_ADDR_W-1:0] out_wd_q, out_wd_d;
  logic                  out_wreg_q, out_wreg_d;

  // Walk oldest to youngest so the lowest-index (youngest) match is applied last.
  function automatic logic [DATA_W-1:0] resolve_op(
    input logic                          rd_en,
    input logic [REG_ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]             rf_data,
    input logic [DATA_W-1:0]             imm,
    input logic [NUM_FWD-1:0]            we,
    input logic [NUM_FWD*REG_ADDR_W-1:0] wd,
    input logic [NUM_FWD*DATA_W-1:0]     data
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (we[i] && (wd[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
        val = data[i*DATA_W +: DATA_W];
      end
    end
    if (addr == '0) val = '0;
    if (!rd_en)     val = imm;
    return val;
  endfunction

  assign reg1_res = resolve_op(in_rs_rd, in_rs, in_rs_data, in_imm, fwd_we, fwd_wd, fwd_data);
  assign reg2_res = resolve_op(in_rt_rd, in_rt, in_rt_data, in_imm, fwd_we, fwd_wd, fwd_data);

`ifdef ID_MOVCOND_EN
  always_comb begin
    wreg_res = in_wreg;
    if (in_aluop == EXE_MOVN_OP) begin
      wreg_res = (reg2_res != '0);
    end else if (in_aluop == EXE_MOVZ_OP) begin
      wreg_res = (reg2_res == '0);
    end
  end
`else
  assign wreg_res = in_wreg;
`endif

  id_scoreboard #(
    .REG_NUM (REG_NUM),
    .LAT_W   (LAT_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set),
    .set_addr  (in_wd),
    .set_lat   (in_lat),
    .rd_addr_a (in_rs),
    .rd_addr_b (in_rt),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  assign hazard   = (in_rs_rd & busy_a) | (in_rt_rd & busy_b);
  assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;
  assign sb_set   = accept & in_wreg & (in_wd != '0) & (in_lat != '0);
  assign stall_o  = in_valid & ~in_ready & ~flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_aluop_d  = out_aluop_q;
    out_alusel_d = out_alusel_q;
    out_reg1_d   = out_reg1_q;
    out_reg2_d   = out_reg2_q;
    out_wd_d     = out_wd_q;
    out_wreg_d   = out_wreg_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_aluop_d  = in_aluop;
      out_alusel_d = in_alusel;
      out_reg1_d   = reg1_res;
      out_reg2_d   = reg2_res;
      out_wd_d     = in_wd;
      out_wreg_d   = wreg_res;
    end else if (flush || !out_valid_q || out_ready) begin
      // Emptied slot carries a bubble so EX never sees a stale write.
      out_valid_d = 1'b0;
      out_aluop_d = EXE_NOP_OP;
      out_wreg_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_aluop_q  <= EXE_NOP_OP;
      out_alusel_q <= EXE_RES_NOP;
      out_reg1_q   <= '0;
      out_reg2_q   <= '0;
      out_wd_q     <= '0;
      out_wreg_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_aluop_q  <= out_aluop_d;
      out_alusel_q <= out_alusel_d;
      out_reg1_q   <= out_reg1_d;
      out_reg2_q   <= out_reg2_d;
      out_wd_q     <= out_wd_d;
      out_wreg_q   <= out_wreg_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_aluop  = out_aluop_q;
  assign out_alusel = out_alusel_q;
  assign out_reg1   = out_reg1_q;
  assign out_reg2   = out_reg2_q;
  assign out_wd     = out_wd_q;
  assign out_wreg   = out_wreg_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Randomized bench for id_issue_ctrl against a behavioural model, plus directed scenarios.
module tb_id_issue_ctrl;
  import id_issue_ctrl_pkg::*;

`ifdef ID_MOVCOND_EN
  localparam bit MOVCOND = 1'b1;
`else
  localparam bit MOVCOND = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_aluop;
  logic [2:0]  in_alusel;
  logic [4:0]  in_rs, in_rt, in_wd;
  logic        in_rs_rd, in_rt_rd, in_wreg;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic [1:0]  in_lat;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_wd;
  logic [63:0] fwd_data;
  logic        flush, out_valid, out_ready, out_wreg, stall_o;
  logic [7:0]  out_aluop;
  logic [2:0]  out_alusel;
  logic [31:0] out_reg1, out_reg2;
  logic [4:0]  out_wd;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  id_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_alusel(in_alusel), .in_rs(in_rs), .in_rt(in_rt),
    .in_rs_rd(in_rs_rd), .in_rt_rd(in_rt_rd), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_lat(in_lat), .fwd_we(fwd_we), .fwd_wd(fwd_wd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .out_reg1(out_reg1),
    .out_reg2(out_reg2), .out_wd(out_wd), .out_wreg(out_wreg), .stall_o(stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: pending-cycle count per register and the expected ID/EX contents.
  int          sb_m [32];
  logic        m_valid, m_wreg;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic [31:0] m_reg1, m_reg2;
  logic [4:0]  m_wd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) sb_m[r] = 0;
    m_valid = 1'b0; m_wreg = 1'b0; m_aluop = 8'h00; m_alusel = 3'b000;
    m_reg1 = 32'h0; m_reg2 = 32'h0; m_wd = 5'h0;
  endfunction

  function automatic logic [31:0] model_operand(input logic rd, input logic [4:0] a,
                                                input logic [31:0] rf);
    if (!rd) return in_imm;
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < 2; i++)
      if (fwd_we[i] && fwd_wd[i*5 +: 5] == a) return fwd_data[i*32 +: 32];
    return rf;
  endfunction

  function automatic bit model_ready();
    bit haz;
    haz = (in_rs_rd && in_rs != 0 && sb_m[in_rs] != 0) ||
          (in_rt_rd && in_rt != 0 && sb_m[in_rt] != 0);
    return (!m_valid || out_ready) && !haz && !flush;
  endfunction

  function automatic logic model_wreg(input logic [31:0] r2);
    if (MOVCOND && in_aluop == EXE_MOVN_OP) return r2 != 0;
    if (MOVCOND && in_aluop == EXE_MOVZ_OP) return r2 == 0;
    return in_wreg;
  endfunction

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int r = 0; r < 32; r++) if (sb_m[r] > 0) sb_m[r] = sb_m[r] - 1;
      if (acc && in_wreg && in_wd != 0 && in_lat != 0) sb_m[in_wd] = int'(in_lat);
      if (acc) begin
        m_valid  = 1'b1;
        m_aluop  = in_aluop;
        m_alusel = in_alusel;
        m_reg1   = model_operand(in_rs_rd, in_rs, in_rs_data);
        m_reg2   = model_operand(in_rt_rd, in_rt, in_rt_data);
        m_wd     = in_wd;
        m_wreg   = model_wreg(m_reg2);
      end else if (flush || !m_valid || out_ready) begin
        m_valid = 1'b0; m_aluop = 8'h00; m_wreg = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, model_ready());
    chk("stall_o", stall_o, in_valid && !model_ready() && !flush);
    chk("out_valid", out_valid, m_valid);
    chk("out_aluop", out_aluop, m_aluop);
    chk("out_wreg", out_wreg, m_wreg);
    if (m_valid) begin
      chk("out_alusel", out_alusel, m_alusel);
      chk("out_reg1", out_reg1, m_reg1);
      chk("out_reg2", out_reg2, m_reg2);
      chk("out_wd", out_wd, m_wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_aluop = EXE_NOP_OP; in_alusel = EXE_RES_NOP;
    in_rs = 0; in_rt = 0; in_rs_rd = 0; in_rt_rd = 0; in_rs_data = 0; in_rt_data = 0;
    in_imm = 0; in_wd = 0; in_wreg = 0; in_lat = 0; fwd_we = 0; fwd_wd = 0; fwd_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic random_inputs();
    case ($urandom_range(0, 4))
      0: in_aluop = EXE_ADD_OP;
      1: in_aluop = EXE_OR_OP;
      2: in_aluop = EXE_LW_OP;
      3: in_aluop = EXE_MOVN_OP;
      default: in_aluop = EXE_MOVZ_OP;
    endcase
    in_valid   = ($urandom_range(0, 3) != 0);
    in_alusel  = 3'($urandom_range(0, 7));
    in_rs      = 5'($urandom_range(0, 7));
    in_rt      = 5'($urandom_range(0, 7));
    in_rs_rd   = 1'($urandom_range(0, 1));
    in_rt_rd   = 1'($urandom_range(0, 1));
    in_rs_data = $urandom;
    in_rt_data = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    in_imm     = $urandom;
    in_wd      = 5'($urandom_range(0, 7));
    in_wreg    = 1'($urandom_range(0, 1));
    in_lat     = 2'($urandom_range(0, 3));
    fwd_we     = 2'($urandom_range(0, 3));
    fwd_wd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    fwd_data   = {$urandom, (($urandom_range(0, 3) == 0) ? 32'h0 : $urandom)};
    flush      = ($urandom_range(0, 9) == 0);
    out_ready  = ($urandom_range(0, 3) != 0);
    rst        = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      random_inputs();
      tick();
    end

    // Mid-stream reset clears everything asynchronously.
    rst = 1'b0;
    random_inputs();
    rst = 1'b0;
    in_valid = 1; out_ready = 1; flush = 0; in_rs_rd = 0; in_rt_rd = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_aluop", out_aluop, 8'h00);
    chk("rst_out_alusel", out_alusel, 0);
    chk("rst_out_reg1", out_reg1, 0);
    chk("rst_out_reg2", out_reg2, 0);
    chk("rst_out_wd", out_wd, 0);
    chk("rst_out_wreg", out_wreg, 0);
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Forwarding priority: youngest source wins, register 0 never forwarded.
    in_valid = 1; in_aluop = EXE_OR_OP; in_alusel = EXE_RES_LOGIC;
    in_rs = 5; in_rs_rd = 1; in_rs_data = 32'h55555555;
    fwd_we = 2'b11; fwd_wd = {5'd5, 5'd5}; fwd_data = {32'h11111111, 32'hAAAA0000};
    tick();
    chk("fwd_prio_valid", out_valid, 1);
    chk("fwd_prio_reg1", out_reg1, 32'hAAAA0000);
    fwd_we = 2'b10;
    tick();
    chk("fwd_mem_reg1", out_reg1, 32'h11111111);
    fwd_we = 2'b11; in_rs = 0;
    tick();
    chk("fwd_r0_reg1", out_reg1, 32'h0);

    // Load-use: one stall cycle, then the dependent add issues.
    fwd_we = 0; in_rs_rd = 0; in_rt_rd = 0;
    in_aluop = EXE_LW_OP; in_alusel = EXE_RES_LOAD; in_wd = 8; in_wreg = 1; in_lat = 1;
    tick();
    chk("lw_aluop", out_aluop, EXE_LW_OP);
    in_aluop = EXE_ADD_OP; in_alusel = EXE_RES_ARITH; in_rs = 8; in_rs_rd = 1;
    in_rs_data = 32'h0000BEEF; in_wd = 10; in_lat = 0;
    stall_cnt = 0;
    #1;
    chk("lu_in_ready", in_ready, 0);
    if (stall_o) stall_cnt++;
    tick();
    if (stall_o) stall_cnt++;
    chk("lu_in_ready_after", in_ready, 1);
    tick();
    chk("lu_stall_pulses", stall_cnt, 1);
    chk("lu_add_aluop", out_aluop, EXE_ADD_OP);
    chk("lu_add_reg1", out_reg1, 32'h0000BEEF);

    // Back-pressure holds the register; release loads the waiting instruction.
    out_ready = 0;
    in_aluop = EXE_OR_OP; in_alusel = EXE_RES_LOGIC; in_rs_rd = 0; in_imm = 32'h00C0FFEE;
    in_wd = 9; in_wreg = 1; in_lat = 2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold_aluop", out_aluop, EXE_ADD_OP);
      chk("bp_hold_reg1", out_reg1, 32'h0000BEEF);
    end
    out_ready = 1;
    tick();
    chk("bp_load_aluop", out_aluop, EXE_OR_OP);
    chk("bp_load_reg1", out_reg1, 32'h00C0FFEE);

    // Flush kills held and incoming; r9 entry keeps counting down.
    out_ready = 0; flush = 1;
    in_aluop = EXE_ADD_OP; in_alusel = EXE_RES_ARITH; in_wd = 11; in_lat = 1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    chk("fl_stall", stall_o, 0);
    tick();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_aluop", out_aluop, 8'h00);
    flush = 0; out_ready = 1; in_rs = 9; in_rs_rd = 1; in_wd = 0; in_wreg = 0; in_lat = 0;
    #1;
    chk("fl_sb_busy", in_ready, 0);
    tick();
    chk("fl_sb_done", in_ready, 1);
    in_rs = 11;
    #1;
    chk("fl_killed_no_sb", in_ready, 1);

    // Conditional moves.
    in_aluop = EXE_MOVN_OP; in_alusel = EXE_RES_MOVE; in_rs_rd = 0;
    in_rt = 3; in_rt_rd = 1; in_rt_data = 32'hFFFFFFFF; in_wd = 4; in_wreg = 1;
    fwd_we = 2'b01; fwd_wd = {5'd0, 5'd3}; fwd_data = {32'h0, 32'h0};
    tick();
    chk("movn_zero_wreg", out_wreg, MOVCOND ? 1'b0 : 1'b1);
    fwd_data = {32'h0, 32'h1};
    tick();
    chk("movn_one_wreg", out_wreg, 1);
    in_aluop = EXE_MOVZ_OP;
    tick();
    chk("movz_one_wreg", out_wreg, MOVCOND ? 1'b0 : 1'b1);

    idle_inputs();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
